// File: rtl/sap_pkg.sv
// Shared SAP-1 loader definitions: FSM state encoding, RAM depth and header field layout.
package sap_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam int RAM_DEPTH    = 16;

    // Header byte: upper nibble is the base address, lower nibble is word count minus one.
    localparam int HDR_BASE_MSB = 7;
    localparam int HDR_BASE_LSB = 4;
    localparam int HDR_CNT_MSB  = 3;
    localparam int HDR_CNT_LSB  = 0;

endpackage

// File: rtl/sum8_acc.sv
// Mod-2^W running sum with synchronous clear and add-enable; used for the load checksum.
module sum8_acc #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         add_en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sum_q <= '0;
        end else if (add_en_i) begin
            sum_q <= sum_q + din_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// SAP-1 program loader: streams a header plus data bytes into the 16x8 RAM, holding the CPU cleared meanwhile.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte (CHK state, err output).
module prog_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_nclr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic              in_ready_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              cpu_nclr_q;
    logic              busy_q;
    logic              done_q;

    logic xfer;
    logic start_take;

    assign xfer       = in_valid && in_ready_q;
    // busy is low exactly in IDLE, DONE and ERR, the states that honour start.
    assign start_take = start && !busy_q;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic              err_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    sum8_acc #(.W(DATA_W)) u_sum (
        .clk_i    (CLK),
        .rst_i    (CLR),
        .clr_i    (start_take),
        .add_en_i (xfer && (state_q == HDR || state_q == DATA)),
        .din_i    (in_data),
        .sum_o    (sum_q)
    );

    assign sum_d = sum_q + in_data;
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_nclr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q       <= 1'b0;
`endif
        end else begin
            ram_we_q <= 1'b0;
            if (start_take) begin
                state_q    <= HDR;
                busy_q     <= 1'b1;
                cpu_nclr_q <= 1'b0;
                done_q     <= 1'b0;
                in_ready_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                err_q      <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: cpu_nclr_q <= 1'b1;
                    HDR: begin
                        if (xfer) begin
                            base_q  <= in_data[HDR_BASE_MSB:HDR_BASE_LSB];
                            cnt_q   <= in_data[HDR_CNT_MSB:HDR_CNT_LSB];
                            idx_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (xfer) begin
                            ram_we_q    <= 1'b1;
                            ram_addr_q  <= base_q + idx_q;
                            ram_wdata_q <= in_data;
                            in_ready_q  <= 1'b0;
                            state_q     <= WR;
                        end
                    end
                    WR: begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == cnt_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_q    <= CHK;
                            in_ready_q <= 1'b1;
`else
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_nclr_q <= 1'b1;
`endif
                        end else begin
                            state_q    <= DATA;
                            in_ready_q <= 1'b1;
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (xfer) begin
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            if (sum_d == '0) begin
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                cpu_nclr_q <= 1'b1;
                            end else begin
                                state_q    <= ERR;
                                err_q      <= 1'b1;
                            end
                        end
                    end
`endif
                    DONE, ERR: ;
                    default: begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_nclr  = cpu_nclr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, basic load, wrap, streaming backpressure, checksum fail, mid-load clear.
module tb_prog_loader;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, ram_we, cpu_nclr, busy, done, err;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_nclr  (cpu_nclr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  nclr_viol = 0;
    int  wr_rdy_viol = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge CLK) begin
        cyc++;
        if (ram_we === 1'b1) begin
            wq.push_back('{ram_addr, ram_wdata, cyc});
            if (in_ready !== 1'b0) wr_rdy_viol++;
        end
        if (busy === 1'b1 && cpu_nclr === 1'b1) nclr_viol++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || err === 1'b1) break;
            tick();
        end
    endtask

    task automatic chk_wr(input int i, input logic [3:0] a, input logic [7:0] d);
        if (i < wq.size()) begin
            check($sformatf("wr%0d_addr", i), wq[i].a, a);
            check($sformatf("wr%0d_data", i), wq[i].d, d);
        end else begin
            check($sformatf("wr%0d_missing", i), 32'd0, 32'd1);
        end
    endtask

    function automatic logic [7:0] cs5(input logic [7:0] h, a, b, c, d);
        logic [7:0] s;
        s = h + a + b + c + d;
        return 8'h00 - s;
    endfunction

    logic [7:0] stream [6];
    int         nbytes;
    int         k;
    logic       rdy;

    initial begin
        // Reset held two cycles
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_nclr", cpu_nclr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        CLR = 1'b0;
        tick();
        check("idle_cpu_nclr", cpu_nclr, 1);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);

        // Basic load: base 0, 4 words
        pulse_start();
        check("sess_busy", busy, 1);
        check("sess_cpu_nclr", cpu_nclr, 0);
        check("sess_in_ready", in_ready, 1);
        wq.delete();
        send(8'h03);
        send(8'h09);
        check("lat_ram_we", ram_we, 1);
        check("lat_ram_addr", ram_addr, 4'h0);
        check("lat_ram_wdata", ram_wdata, 8'h09);
        check("wr_in_ready", in_ready, 0);
        send(8'h1E);
        send(8'h2F);
        send(8'hE0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(cs5(8'h03, 8'h09, 8'h1E, 8'h2F, 8'hE0));
`endif
        wait_end();
        check("basic_done", done, 1);
        check("basic_err", err, 0);
        check("basic_busy", busy, 0);
        check("basic_cpu_nclr", cpu_nclr, 1);
        check("basic_nwr", wq.size(), 4);
        chk_wr(0, 4'h0, 8'h09);
        chk_wr(1, 4'h1, 8'h1E);
        chk_wr(2, 4'h2, 8'h2F);
        chk_wr(3, 4'h3, 8'hE0);
        check("basic_nclr_held", nclr_viol, 0);

        // Address wrap from base E; restart from DONE
        pulse_start();
        check("wrap_done_cleared", done, 0);
        wq.delete();
        send(8'hE3);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(cs5(8'hE3, 8'hAA, 8'hBB, 8'hCC, 8'hDD));
`endif
        wait_end();
        check("wrap_done", done, 1);
        check("wrap_nwr", wq.size(), 4);
        chk_wr(0, 4'hE, 8'hAA);
        chk_wr(1, 4'hF, 8'hBB);
        chk_wr(2, 4'h0, 8'hCC);
        chk_wr(3, 4'h1, 8'hDD);

        // Continuous in_valid: one write every 2 cycles, no drop or duplicate
        stream[0] = 8'h13;
        stream[1] = 8'h11;
        stream[2] = 8'h22;
        stream[3] = 8'h33;
        stream[4] = 8'h44;
        stream[5] = cs5(8'h13, 8'h11, 8'h22, 8'h33, 8'h44);
`ifdef PROG_LOADER_CHECKSUM_EN
        nbytes = 6;
`else
        nbytes = 5;
`endif
        pulse_start();
        wq.delete();
        k = 0;
        in_valid = 1'b1;
        in_data  = stream[0];
        for (int g = 0; g < 40 && k < nbytes; g++) begin
            rdy = in_ready;
            tick();
            if (rdy === 1'b1) begin
                k++;
                if (k < nbytes) in_data = stream[k];
            end
        end
        in_valid = 1'b0;
        check("bp_all_sent", k, nbytes);
        wait_end();
        check("bp_done", done, 1);
        check("bp_nwr", wq.size(), 4);
        chk_wr(0, 4'h1, 8'h11);
        chk_wr(1, 4'h2, 8'h22);
        chk_wr(2, 4'h3, 8'h33);
        chk_wr(3, 4'h4, 8'h44);
        for (int i = 1; i < 4; i++) begin
            if (i < wq.size()) check($sformatf("bp_gap%0d", i), wq[i].c - wq[i-1].c, 2);
        end
        check("bp_wr_ready_low", wr_rdy_viol, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum lands in ERR with the CPU still held
        pulse_start();
        send(8'h00);
        send(8'h55);
        send(8'h00);
        wait_end();
        check("cs_err", err, 1);
        check("cs_done", done, 0);
        check("cs_cpu_nclr", cpu_nclr, 0);
        check("cs_busy", busy, 0);
        tick();
        check("cs_err_sticky", err, 1);
        pulse_start();
        check("cs_err_cleared", err, 0);
        check("cs_restart_busy", busy, 1);
`else
        pulse_start();
`endif

        // CLR after 2 of 4 words
        wq.delete();
        send(8'h53);
        send(8'h5A);
        send(8'hA5);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_ram_we", ram_we, 0);
        check("clr_in_ready", in_ready, 0);
        check("clr_cpu_nclr", cpu_nclr, 0);
        check("clr_nwr", wq.size(), 2);
        chk_wr(0, 4'h5, 8'h5A);
        chk_wr(1, 4'h6, 8'hA5);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) tick();
        check("clr_no_accept_rdy", in_ready, 0);
        check("clr_no_more_wr", wq.size(), 2);
        check("clr_idle_nclr", cpu_nclr, 1);
        check("clr_idle_busy", busy, 0);
        in_valid = 1'b0;
        check("final_nclr_held", nclr_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
